aq_vlsu_ld_merge: RTL
=====================

// Module: aq_vlsu_ld_merge
// PURPOSE
//  Load-data merge stage directly downstream of the VLSU byte-rotation stage.
//  Takes rotated 64-bit beats plus byte enables and forwards single-beat loads.
//  Merges the two halves of a line-crossing (split) load into one beat.
//  Drives the registered result to VRF write-back over a valid/ready handshake.
// PARAMETERS
//  DATAW   64         data width in bits; must be a multiple of 8
//  BEW     DATAW/8    byte-enable width; derived, do not override
//  TAGW    5          width of the sideband tag carried with each beat
// PORTS
//  forever_cpuclk   in   1      clock
//  cpurst_b         in   1      async reset, active low
//  rtu_yy_xx_flush  in   1      pipeline flush, synchronous
//  rot_vld          in   1      rotated beat valid
//  rot_rdy          out  1      this block can accept a beat
//  rot_data         in   DATAW  rotated load data
//  rot_be           in   BEW    bytes of rot_data that belong to this access
//  rot_split        in   1      beat belongs to a split (two-beat) access
//  rot_last         in   1      with rot_split: 1 = second beat, 0 = first beat
//  rot_tag          in   TAGW   destination id, carried through unchanged
//  wb_vld           out  1      merged beat valid
//  wb_rdy           in   1      write-back accepts the beat
//  wb_data          out  DATAW  merged data
//  wb_be            out  BEW    merged byte enables
//  wb_tag           out  TAGW   tag of the completing beat
//  merge_err        out  1      one-cycle pulse on a split-protocol violation
// BEHAVIOUR
//  - Reset: wb_vld=0, wb_data=0, wb_be=0, wb_tag=0, merge_err=0, state=IDLE,
//    merge buffer cleared (buf_data=0, buf_be=0).
//  - Accept: acc = rot_vld & rot_rdy.
//    rot_rdy = ~rtu_yy_xx_flush & (~wb_vld | wb_rdy); no dependence on rot_vld.
//  - Output register: a single entry. It holds value while wb_vld & ~wb_rdy.
//    It clears on wb_rdy when nothing new is loaded in the same cycle.
//  - FSM states:
//    IDLE --acc & rot_split & ~rot_last--> WAIT2: buf_data<=rot_data & be-mask,
//      buf_be<=rot_be; no output.
//    IDLE --acc & ~rot_split--> IDLE: output reg <= rot_data/rot_be/rot_tag.
//    WAIT2 --acc & rot_split & rot_last--> IDLE: output reg loaded with
//      data = (buf_data & ~m) | (rot_data & m), m = byte-expand(rot_be);
//      wb_be = buf_be | rot_be; wb_tag = rot_tag.
//  - Latency: wb_vld rises in the cycle after the completing beat is accepted.
//    Throughput is 1 beat/cycle when wb_rdy is held high.
//  - Overlapping bytes (buf_be & rot_be != 0): second-beat bytes win.
//    No error is flagged for overlap.
//  - Violation: second beat while in IDLE.
//    merge_err=1 next cycle; beat is forwarded as a single beat.
//  - Violation: first beat or non-split beat while in WAIT2.
//    merge_err=1 next cycle; partial buffer is discarded.
//    The new beat is then handled as if the state were IDLE.
//  - Flush (rtu_yy_xx_flush=1): next cycle state=IDLE, buf_be=0, wb_vld=0.
//    rot_rdy=0 during the flush cycle, so no beat is accepted.
//    Flush takes priority over wb_rdy and over any merge.
//  - Reset mid-operation clears everything asynchronously.
//    A pending split is lost and no merge_err is raised.
//  - wb_data, wb_be and wb_tag change only when the output register loads.
// TESTING
//  1. Single beat: rot_data=64'h1122334455667788, be=8'hFF, split=0, wb_rdy=1
//     -> next cycle wb_vld=1, data identical, wb_be=8'hFF.
//  2. Split pair: first beat be=8'h0F, data=..._AAAAAAAA; then second beat
//     be=8'hF0, data=BBBBBBBB_...
//     -> one output, data=64'hBBBBBBBB_AAAAAAAA, be=8'hFF, tag of second beat.
//  3. Backpressure: wb_rdy=0 for 3 cycles with wb_vld=1
//     -> rot_rdy=0 and wb_* stable; wb_rdy=1 -> drains; next beat accepted
//     in the same cycle.
//  4. Flush in WAIT2: first beat accepted, then flush
//     -> wb_vld=0, state IDLE; a following second beat gives merge_err=1
//     and a single-beat output.
//  5. Async reset asserted while wb_vld=1 and state=WAIT2
//     -> all outputs 0 immediately; after release a single beat passes normally.
//  6. Back-to-back: single, split pair, single, with wb_rdy=1
//     -> three outputs, in order, in cycles 2, 4 and 5.

Source files
------------

// File: rtl/aq_vlsu_ld_merge.sv
// aq_vlsu_ld_merge: merges the two halves of a line-crossing load and forwards
// single-beat loads to VRF write-back through a one-entry output register.
module aq_vlsu_ld_merge #(
    parameter int DATAW = 64,
    parameter int BEW   = DATAW / 8,
    parameter int TAGW  = 5
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst_b,
    input  logic             rtu_yy_xx_flush,
    input  logic             rot_vld,
    output logic             rot_rdy,
    input  logic [DATAW-1:0] rot_data,
    input  logic [BEW-1:0]   rot_be,
    input  logic             rot_split,
    input  logic             rot_last,
    input  logic [TAGW-1:0]  rot_tag,
    output logic             wb_vld,
    input  logic             wb_rdy,
    output logic [DATAW-1:0] wb_data,
    output logic [BEW-1:0]   wb_be,
    output logic [TAGW-1:0]  wb_tag,
    output logic             merge_err
);
    typedef enum logic {IDLE, WAIT2} state_e;

    state_e           state_q, state_d;
    logic [DATAW-1:0] buf_data_q, buf_data_d, wb_data_q, wb_data_d, m;
    logic [BEW-1:0]   buf_be_q, buf_be_d, wb_be_q, wb_be_d;
    logic [TAGW-1:0]  wb_tag_q, wb_tag_d;
    logic             wb_vld_q, wb_vld_d, err_q, err_d;
    logic             acc, first, second;

    for (genvar b = 0; b < BEW; b++) begin : g_mask
        assign m[8*b +: 8] = {8{rot_be[b]}};
    end

    assign rot_rdy = ~rtu_yy_xx_flush & (~wb_vld_q | wb_rdy);
    assign acc     = rot_vld & rot_rdy;
    assign first   = rot_split & ~rot_last;
    assign second  = rot_split & rot_last;

    always_comb begin
        state_d    = state_q;
        buf_data_d = buf_data_q;
        buf_be_d   = buf_be_q;
        wb_vld_d   = wb_vld_q & ~wb_rdy;
        wb_data_d  = wb_data_q;
        wb_be_d    = wb_be_q;
        wb_tag_d   = wb_tag_q;
        err_d      = 1'b0;
        if (rtu_yy_xx_flush) begin
            state_d  = IDLE;
            buf_be_d = '0;
            wb_vld_d = 1'b0;
        end else if (acc) begin
            // a second beat is only legal in WAIT2; anything else there is a violation
            err_d = (state_q == WAIT2) ^ second;
            if (state_q == WAIT2 && second) begin
                state_d   = IDLE;
                buf_be_d  = '0;
                wb_vld_d  = 1'b1;
                wb_data_d = (buf_data_q & ~m) | (rot_data & m);
                wb_be_d   = buf_be_q | rot_be;
                wb_tag_d  = rot_tag;
            end else if (first) begin
                state_d    = WAIT2;
                buf_data_d = rot_data & m;
                buf_be_d   = rot_be;
            end else begin
                state_d   = IDLE;
                buf_be_d  = '0;
                wb_vld_d  = 1'b1;
                wb_data_d = rot_data;
                wb_be_d   = rot_be;
                wb_tag_d  = rot_tag;
            end
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q    <= IDLE;
            buf_data_q <= '0;
            buf_be_q   <= '0;
            wb_vld_q   <= 1'b0;
            wb_data_q  <= '0;
            wb_be_q    <= '0;
            wb_tag_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_data_q <= buf_data_d;
            buf_be_q   <= buf_be_d;
            wb_vld_q   <= wb_vld_d;
            wb_data_q  <= wb_data_d;
            wb_be_q    <= wb_be_d;
            wb_tag_q   <= wb_tag_d;
            err_q      <= err_d;
        end
    end

    assign wb_vld    = wb_vld_q;
    assign wb_data   = wb_data_q;
    assign wb_be     = wb_be_q;
    assign wb_tag    = wb_tag_q;
    assign merge_err = err_q;
endmodule
